// File: rtl/rg_response_reader_if.sv
// Ring-generator / response-word bundle between the response reader (master)
// and the generator plus register-side consumer (slave).
interface rg_response_reader_if;
   logic        oRgEn;         // generator enable
   logic        oRgInit;       // generator init strobe
   logic [63:0] oRgChallenge;  // challenge presented to the generator
   logic        iSerial;       // generator serial output (state[0])
   logic [31:0] oData;         // collected response word
   logic        oValid;        // oData holds an unaccepted word
   logic        iReady;        // consumer accepts oData

   modport master (
      output oRgEn, oRgInit, oRgChallenge, oData, oValid,
      input  iSerial, iReady
   );

   modport slave (
      input  oRgEn, oRgInit, oRgChallenge, oData, oValid,
      output iSerial, iReady
   );
endinterface

// File: rtl/rg_response_reader.sv
// Response reader: loads a challenge into the ring generator, runs the
// warm-up, then packs the serial stream into 32-bit words handed out over
// valid/ready. The generator is frozen while a word waits for acceptance,
// so the captured bit stream stays contiguous across words.
module rg_response_reader #(
   parameter int WARMUP = 128,
   parameter int WCNT_W = 8
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iStart,
   input  logic                 iStop,
   input  logic [63:0]          iChallenge,
   input  logic [7:0]           iNumWords,
   output logic                 oBusy,
   output logic                 oDone,
   rg_response_reader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_WARM    = 3'd2,
      S_COLLECT = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   // Last warm-up count; unused when WARMUP is 0 because LOAD skips WARM.
   localparam logic [WCNT_W-1:0] WARM_LAST = (WARMUP > 0) ? WCNT_W'(WARMUP - 1) : '0;

   state_t              state_q,  state_d;
   logic [WCNT_W-1:0]   wcnt_q,   wcnt_d;
   logic [4:0]          bcnt_q,   bcnt_d;
   logic [8:0]          words_q,  words_d;
   logic [31:0]         shift_q,  shift_d;
   logic [31:0]         data_q,   data_d;
   logic [63:0]         chal_q,   chal_d;
   logic                en_q,     en_d;
   logic                init_q,   init_d;
   logic                valid_q,  valid_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;

   // Next-state, counters, datapath and registered outputs derived from next state.
   always_comb begin
      // NOTE: every signal gets a default before any branch; a path that leaves
      // one unassigned would infer a latch instead of combinational logic.
      state_d = state_q;
      wcnt_d  = wcnt_q;
      bcnt_d  = bcnt_q;
      words_d = words_q;
      shift_d = shift_q;
      data_d  = data_q;
      chal_d  = chal_q;
      done_d  = 1'b0;

      if (iStop) begin
         // Abort wins over everything, including a simultaneous start in IDLE.
         state_d = S_IDLE;
         wcnt_d  = '0;
         bcnt_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (iStart) begin
                  chal_d  = iChallenge;
                  words_d = (iNumWords == 8'd0) ? 9'd256 : {1'b0, iNumWords};
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               wcnt_d  = '0;
               bcnt_d  = '0;
               state_d = (WARMUP > 0) ? S_WARM : S_COLLECT;
            end
            S_WARM: begin
               if (wcnt_q == WARM_LAST) begin
                  wcnt_d  = '0;
                  state_d = S_COLLECT;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
            S_COLLECT: begin
               // Right shift: the first captured bit ends up in bit 0.
               shift_d = {bus.iSerial, shift_q[31:1]};
               bcnt_d  = bcnt_q + 1'b1;
               if (bcnt_q == 5'd31) begin
                  data_d  = shift_d;
                  state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               if (valid_q && bus.iReady) begin
                  words_d = words_q - 9'd1;
                  if (words_q == 9'd1) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_COLLECT;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are registered, so they are decoded from the state being entered.
      en_d    = (state_d == S_LOAD) || (state_d == S_WARM) || (state_d == S_COLLECT);
      init_d  = (state_d == S_LOAD);
      valid_d = (state_d == S_HOLD);
      busy_d  = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset to all-zero outputs.
   always_ff @(posedge iClk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (iRst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
         words_q <= '0;
         shift_q <= '0;
         data_q  <= '0;
         chal_q  <= '0;
         en_q    <= 1'b0;
         init_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
         words_q <= words_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         chal_q  <= chal_d;
         en_q    <= en_d;
         init_q  <= init_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.oRgEn        = en_q;
   assign bus.oRgInit      = init_q;
   assign bus.oRgChallenge = chal_q;
   assign bus.oData        = data_q;
   assign bus.oValid       = valid_q;
   assign oBusy            = busy_q;
   assign oDone            = done_q;

endmodule

// File: doc/rg_response_reader.md
# rg_response_reader

Sequencer and collector on the consuming side of the ring-generator interface. It loads a 64-bit challenge into the generator and clocks it through a programmable warm-up. It then shifts the generator's serial output into 32-bit response words and hands each word to the peripheral register logic over a valid/ready handshake. The generator is stalled while an unaccepted word is held, so no bits are ever lost.

## Interface

Parameters:
- `WARMUP`, default 128: generator cycles between challenge load and first captured bit; 0 is legal and skips warm-up.
- `WCNT_W`, default 8: width of the warm-up counter; must satisfy WARMUP < 2^WCNT_W.

Ports:
- `iClk` input 1: single clock, rising edge.
- `iRst` input 1: reset, synchronous and active-high.
- `iStart` input 1: start request; accepted only in IDLE.
- `iStop` input 1: abort; returns the block to IDLE from any state.
- `iChallenge` input 64: challenge, sampled on the cycle `iStart` is accepted.
- `iNumWords` input 8: words to collect, sampled with `iStart`; 0 means 256.
- `iSerial` input 1: generator serial output (generator `state[0]`).
- `oRgEn` output 1: generator enable.
- `oRgInit` output 1: generator init strobe.
- `oRgChallenge` output 64: registered copy of the challenge.
- `oData` output 32: response word.
- `oValid` output 1: `oData` is valid.
- `iReady` input 1: consumer accepts `oData`.
- `oBusy` output 1: high in every state except IDLE.
- `oDone` output 1: one-cycle pulse after the final word is accepted.

## Operation

FSM states are IDLE, LOAD, WARM, COLLECT and HOLD.

- **IDLE**
  - `oRgEn`, `oRgInit` and `oValid` are 0.
  - `iStart`=1: latch `iChallenge` into `oRgChallenge`, latch `iNumWords` into the remaining-word counter (0 loads 256), then go to LOAD.
- **LOAD** (1 cycle)
  - `oRgEn`=1 and `oRgInit`=1, so the generator loads the challenge at this cycle's edge.
  - Next state is WARM if WARMUP>0, otherwise COLLECT.
- **WARM** (WARMUP cycles)
  - `oRgEn`=1, `oRgInit`=0; the warm-up counter counts 0..WARMUP-1.
  - Next state is COLLECT.
- **COLLECT** (32 cycles)
  - `oRgEn`=1. At each edge, capture `iSerial` (the pre-advance `state[0]`) with shift = {`iSerial`, shift[31:1]}.
  - The first captured bit ends in `oData[0]`; the 32nd ends in `oData[31]`.
  - After the 32nd capture, load `oData` and go to HOLD.
- **HOLD**
  - `oValid`=1 and `oRgEn`=0, so the generator is frozen.
  - On `oValid`&&`iReady`, decrement the word counter. If words remain, go to COLLECT; otherwise go to IDLE and pulse `oDone`.
- **iStop**
  - Has priority over all transitions.
  - In any non-IDLE state: next state is IDLE, `oValid` drops next cycle, no `oDone`, and the partial word is discarded.
- **Other rules**
  - `iStart` is ignored while `oBusy`=1.
  - `iStart` and `iStop` together in IDLE: `iStop` wins and the block stays in IDLE.
  - Bit counter is 5 bits and wraps 31→0 on word completion.
  - Word counter is 9 bits, range 1..256.

## Timing

- **Reset values:** all outputs are 0 (`oData`=0, `oRgChallenge`=0). State is IDLE and all counters are cleared.
- **Reset mid-operation:** behaves like `iStop`, and all outputs are 0 the cycle after `iRst` is sampled.
- **Start latency:** with `iStart` accepted at edge k:
  - LOAD occupies cycle k+1.
  - WARM occupies cycles k+2..k+1+WARMUP.
  - COLLECT occupies the next 32 cycles.
  - `oValid` rises 1+WARMUP+32 cycles after edge k.
- **Handshake:**
  - `oData` is stable while `oValid`=1 and `iReady`=0.
  - Transfer occurs on the edge where both are 1; `oValid` drops the following cycle.
  - `iReady` may be held high permanently.
- **Per-word throughput:** 33 cycles (32 COLLECT + 1 HOLD minimum).
- **Generator alignment:** `oRgEn` is high for exactly 1+WARMUP+32·N cycles per N-word run with no stop. Captured bits are therefore contiguous across words.
- **oDone:** high for exactly 1 cycle, the first cycle back in IDLE after the last transfer.

## Test plan

- **Load and warm-up:** WARMUP=4, `iStart` with `iChallenge`=64'hDEADBEEF_01234567 and `iNumWords`=1 -> `oRgChallenge`=64'hDEADBEEF_01234567; `oRgInit`=1 for exactly 1 cycle; `oRgEn`=1 for 4 WARM cycles and then 32 COLLECT cycles; `oValid` rises 37 cycles after the start edge.
- **Bit ordering:** bench drives `iSerial`=1,0,1,0… starting at the first COLLECT cycle -> `oData`=32'h55555555. Drive 1 for 8 bits then 0 for 24 bits -> `oData`=32'h000000FF.
- **Backpressure:** hold `iReady`=0 for 10 cycles in HOLD -> `oData` unchanged, `oValid`=1 and `oRgEn`=0 throughout. Raise `iReady` -> transfer, then COLLECT resumes with the next `iSerial` bit.
- **Multi-word run:** `iNumWords`=3 with `iReady`=1 -> 3 transfers spaced 33 cycles apart; `oDone` pulses once, 1 cycle after the third transfer; total `oRgEn`-high cycles = 1+WARMUP+96.
- **Abort:** assert `iStop` at COLLECT bit 10 -> IDLE next cycle, `oBusy`=0, no `oValid`, no `oDone`. A new `iStart` then runs normally. A second `iStart` issued while busy is ignored.
- **Reset mid-HOLD:** assert `iRst` while `oValid`=1 -> all outputs 0 the next cycle. `iNumWords`=0 run -> exactly 256 words transferred before `oDone`.
